// File: rtl/snn_syn_pkg.sv
// Shared definitions for the synapse row fetcher: FSM encoding, synapse
// memory address composition and the bit layout of a buffered weight beat.
package snn_syn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Weight beat layout, LSB first: last flag, post index, pre index, weight data.
  localparam int BEAT_LAST_BIT = 0;

  function automatic int beat_width(input int dw, input int saw, input int pw);
    return dw + saw + pw + 1;
  endfunction

  function automatic int beat_post_lsb();
    return 1;
  endfunction

  function automatic int beat_pre_lsb(input int pw);
    return 1 + pw;
  endfunction

  function automatic int beat_data_lsb(input int saw, input int pw);
    return 1 + pw + saw;
  endfunction

  // Row-major synapse address: the presynaptic index selects a row of 2**post_w.
  function automatic logic [31:0] syn_addr(input logic [31:0] pre,
                                           input logic [31:0] post,
                                           input int          post_w);
    return (pre << post_w) | post;
  endfunction

endpackage

// File: rtl/syn_weight_fifo.sv
// Synchronous FIFO for weight beats. Head data is read straight from the
// storage registers and forced to zero while empty so idle outputs stay clean.
module syn_weight_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en_i,
  input  logic [WIDTH-1:0]               wr_data_i,
  input  logic                           rd_en_i,
  output logic                           rd_valid_o,
  output logic [WIDTH-1:0]               rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int CNTW = $clog2(DEPTH+1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             do_rd, do_wr;

  assign do_rd      = rd_en_i && (count_q != '0);
  assign do_wr      = wr_en_i && ((count_q != CNTW'(DEPTH)) || do_rd);
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy, wrapping for non-power-of-two depths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= (wr_ptr_q == PTRW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= (rd_ptr_q == PTRW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CNTW'(do_wr) - CNTW'(do_rd);
    end
  end

endmodule

// File: rtl/synapse_row_fetch.sv
// Streams one row of synaptic weights per popped presynaptic spike, one read
// per cycle, with credit-based flow control into the output buffer.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | popping spikes and issuing row reads
// DRAIN | FIFO empty; waiting for in-flight reads and buffer to empty
// DONE  | one-cycle batch-complete pulse
module synapse_row_fetch
  import snn_syn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SPIKE_AW   = 10,
  parameter int POST_W     = 4,
  parameter int NUM_POST   = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int MEM_LAT    = 1,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start_fetch,
  input  logic [SPIKE_AW-1:0]   i_spike_addr_fifo_data,
  input  logic                  i_spike_addr_fifo_valid,
  output logic                  o_spike_addr_fifo_rden,
  output logic                  o_syn_mem_rden,
  output logic [ADDR_WIDTH-1:0] o_syn_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_syn_mem_rdata,
  output logic                  o_weight_valid,
  input  logic                  i_weight_ready,
  output logic [DATA_WIDTH-1:0] o_weight_data,
  output logic [SPIKE_AW-1:0]   o_weight_pre_idx,
  output logic [POST_W-1:0]     o_weight_post_idx,
  output logic                  o_weight_last,
  output logic                  o_busy,
  output logic                  o_fetch_done,
  output logic [SPIKE_AW:0]     o_spike_count
);

  localparam int BW       = beat_width(DATA_WIDTH, SPIKE_AW, POST_W);
  localparam int POST_LSB = beat_post_lsb();
  localparam int PRE_LSB  = beat_pre_lsb(POST_W);
  localparam int DATA_LSB = beat_data_lsb(SPIKE_AW, POST_W);
  localparam int OCW      = $clog2(OUT_DEPTH+1);
  localparam int CW       = OCW + 1;
  localparam logic [POST_W-1:0] LAST_POST = POST_W'(NUM_POST-1);

  fetch_state_e        state_q;
  logic                busy_q, done_q;
  logic [SPIKE_AW:0]   spike_cnt_q;
  logic                row_active_q;
  logic [SPIKE_AW-1:0] pre_q;
  logic [POST_W-1:0]   post_q;
  logic [CW-1:0]       inflight_q;
  logic [MEM_LAT-1:0]  tag_vld_q;
  logic [SPIKE_AW-1:0] tag_pre_q  [MEM_LAT];
  logic [POST_W-1:0]   tag_post_q [MEM_LAT];

  logic [OCW-1:0] occ;
  logic           credit_ok, issue, row_end, pop_spike, ret_vld, buf_pop;
  logic [BW-1:0]  wr_beat, rd_beat;

  // Credit uses registered counts only, so ready never reaches the read strobe.
  assign credit_ok = ({1'b0, occ} + inflight_q) < CW'(OUT_DEPTH);
  assign issue     = row_active_q && credit_ok;
  assign row_end   = issue && (post_q == LAST_POST);
  assign pop_spike = (state_q == ST_FETCH) && i_spike_addr_fifo_valid &&
                     (!row_active_q || row_end);
  assign ret_vld   = tag_vld_q[MEM_LAT-1];
  assign buf_pop   = o_weight_valid && i_weight_ready;

  assign o_spike_addr_fifo_rden = pop_spike;
  assign o_syn_mem_rden         = issue;
  assign o_syn_mem_addr         = ADDR_WIDTH'(syn_addr(32'(pre_q), 32'(post_q), POST_W));
  assign o_busy                 = busy_q;
  assign o_fetch_done           = done_q;
  assign o_spike_count          = spike_cnt_q;

  // Batch sequencing plus the saturating per-batch spike counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spike_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (i_start_fetch) begin
          state_q     <= ST_FETCH;
          busy_q      <= 1'b1;
          spike_cnt_q <= '0;
        end
        ST_FETCH: if (!row_active_q && !i_spike_addr_fifo_valid) state_q <= ST_DRAIN;
        ST_DRAIN: if (occ == '0 && inflight_q == '0) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (pop_spike && spike_cnt_q != '1) spike_cnt_q <= spike_cnt_q + 1'b1;
    end
  end

  // Row walker: a pop in the row's final issue cycle chains straight into the next row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_active_q <= 1'b0;
      pre_q        <= '0;
      post_q       <= '0;
    end else if (pop_spike) begin
      row_active_q <= 1'b1;
      pre_q        <= i_spike_addr_fifo_data;
      post_q       <= '0;
    end else if (row_end) begin
      row_active_q <= 1'b0;
    end else if (issue) begin
      post_q <= post_q + 1'b1;
    end
  end

  // Tag pipeline aligned with memory latency; reset drops returns still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_q  <= '0;
      inflight_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_pre_q[i]  <= '0;
        tag_post_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0]  <= issue;
      tag_pre_q[0]  <= pre_q;
      tag_post_q[0] <= post_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_pre_q[i]  <= tag_pre_q[i-1];
        tag_post_q[i] <= tag_post_q[i-1];
      end
      inflight_q <= inflight_q + CW'(issue) - CW'(ret_vld);
    end
  end

  // Pack returning data with its tags into a beat.
  always_comb begin
    wr_beat = '0;
    wr_beat[DATA_LSB +: DATA_WIDTH] = i_syn_mem_rdata;
    wr_beat[PRE_LSB +: SPIKE_AW]    = tag_pre_q[MEM_LAT-1];
    wr_beat[POST_LSB +: POST_W]     = tag_post_q[MEM_LAT-1];
    wr_beat[BEAT_LAST_BIT]          = (tag_post_q[MEM_LAT-1] == LAST_POST);
  end

  syn_weight_fifo #(
    .WIDTH (BW),
    .DEPTH (OUT_DEPTH)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (ret_vld),
    .wr_data_i  (wr_beat),
    .rd_en_i    (buf_pop),
    .rd_valid_o (o_weight_valid),
    .rd_data_o  (rd_beat),
    .count_o    (occ)
  );

  assign o_weight_data     = rd_beat[DATA_LSB +: DATA_WIDTH];
  assign o_weight_pre_idx  = rd_beat[PRE_LSB +: SPIKE_AW];
  assign o_weight_post_idx = rd_beat[POST_LSB +: POST_W];
  assign o_weight_last     = rd_beat[BEAT_LAST_BIT];

endmodule

// File: tb/tb_synapse_row_fetch.sv
// Directed bench for synapse_row_fetch with a spike FIFO model, a fixed
// latency memory model and an in-order scoreboard of reads and weights.
module tb_synapse_row_fetch;

  localparam int DW = 8, SAW = 10, PW = 4, NP = 4, AW = 14, ML = 2, OD = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_start_fetch = 1'b0;
  logic [SAW-1:0]  i_spike_addr_fifo_data;
  logic            i_spike_addr_fifo_valid;
  logic            o_spike_addr_fifo_rden;
  logic            o_syn_mem_rden;
  logic [AW-1:0]   o_syn_mem_addr;
  logic [DW-1:0]   i_syn_mem_rdata;
  logic            o_weight_valid;
  logic            i_weight_ready = 1'b1;
  logic [DW-1:0]   o_weight_data;
  logic [SAW-1:0]  o_weight_pre_idx;
  logic [PW-1:0]   o_weight_post_idx;
  logic            o_weight_last;
  logic            o_busy;
  logic            o_fetch_done;
  logic [SAW:0]    o_spike_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  synapse_row_fetch #(
    .DATA_WIDTH(DW), .SPIKE_AW(SAW), .POST_W(PW), .NUM_POST(NP),
    .ADDR_WIDTH(AW), .MEM_LAT(ML), .OUT_DEPTH(OD)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_start_fetch           (i_start_fetch),
    .i_spike_addr_fifo_data  (i_spike_addr_fifo_data),
    .i_spike_addr_fifo_valid (i_spike_addr_fifo_valid),
    .o_spike_addr_fifo_rden  (o_spike_addr_fifo_rden),
    .o_syn_mem_rden          (o_syn_mem_rden),
    .o_syn_mem_addr          (o_syn_mem_addr),
    .i_syn_mem_rdata         (i_syn_mem_rdata),
    .o_weight_valid          (o_weight_valid),
    .i_weight_ready          (i_weight_ready),
    .o_weight_data           (o_weight_data),
    .o_weight_pre_idx        (o_weight_pre_idx),
    .o_weight_post_idx       (o_weight_post_idx),
    .o_weight_last           (o_weight_last),
    .o_busy                  (o_busy),
    .o_fetch_done            (o_fetch_done),
    .o_spike_count           (o_spike_count)
  );

  function automatic logic [DW-1:0] wgen(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = (a * 14'd37) ^ (a >> 6) ^ 14'h05a;
    return t[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Spike FIFO model (show-ahead).
  logic [SAW-1:0] sf_mem [64];
  logic [5:0]     sf_head = '0;
  logic [5:0]     sf_tail = '0;
  assign i_spike_addr_fifo_valid = (sf_head != sf_tail);
  assign i_spike_addr_fifo_data  = sf_mem[sf_head];
  always @(posedge clk) if (o_spike_addr_fifo_rden && i_spike_addr_fifo_valid) sf_head <= sf_head + 1'b1;

  // Memory model: data appears exactly ML cycles after the read strobe.
  logic [ML-1:0] mv = '0;
  logic [AW-1:0] ma [ML];
  always @(posedge clk) begin
    mv[0] <= o_syn_mem_rden;
    ma[0] <= o_syn_mem_addr;
    for (int i = 1; i < ML; i++) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
    end
  end
  assign i_syn_mem_rdata = mv[ML-1] ? wgen(ma[ML-1]) : 8'hEE;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [SAW-1:0] pre;
    logic [PW-1:0]  post;
    logic           last;
  } beat_t;

  beat_t         exp_q [$];
  logic [AW-1:0] expa_q [$];
  beat_t         mon_eb;
  logic [AW-1:0] mon_ea;

  task automatic add_spike(input logic [SAW-1:0] s);
    sf_mem[sf_tail] = s;
    sf_tail = sf_tail + 1'b1;
    for (int p = 0; p < NP; p++) begin
      logic [AW-1:0] a;
      beat_t b;
      a = {s, PW'(p)};
      b.d = wgen(a); b.pre = s; b.post = PW'(p); b.last = (p == NP-1);
      expa_q.push_back(a);
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard: every read address and every transferred weight in issue order.
  always @(negedge clk) begin
    if (rst_n && o_syn_mem_rden === 1'b1) begin
      mon_ea = 'x;
      if (expa_q.size() > 0) mon_ea = expa_q.pop_front();
      chk("read_addr", 32'(o_syn_mem_addr), 32'(mon_ea));
    end
    if (o_weight_valid === 1'b1 && i_weight_ready) begin
      mon_eb = 'x;
      if (exp_q.size() > 0) mon_eb = exp_q.pop_front();
      chk("weight_beat", 32'({o_weight_data, o_weight_pre_idx, o_weight_post_idx, o_weight_last}),
          32'(mon_eb));
    end
  end

  task automatic wait_done(input int max_cyc, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (o_fetch_done === 1'b1) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_fetch_done, 0);
    chk("rst_valid", o_weight_valid, 0);
    chk("rst_mem_rden", o_syn_mem_rden, 0);
    chk("rst_fifo_rden", o_spike_addr_fifo_rden, 0);
    chk("rst_count", o_spike_count, 0);

    // T1: single spike 5, latency and done pulse
    add_spike(10'd5);
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0;
    @(negedge clk);
    chk("t1_c1_pop", o_spike_addr_fifo_rden, 1);
    chk("t1_c1_busy", o_busy, 1);
    chk("t1_c1_noread", o_syn_mem_rden, 0);
    @(negedge clk);
    chk("t1_c2_read", o_syn_mem_rden, 1);
    chk("t1_c2_addr", o_syn_mem_addr, 32'h050);
    repeat (ML) @(negedge clk);
    chk("t1_valid_before", o_weight_valid, 0);
    @(negedge clk);
    chk("t1_valid_lat", o_weight_valid, 1);
    wait_done(40, found);
    chk("t1_done_seen", found, 1);
    chk("t1_count", o_spike_count, 1);
    @(negedge clk);
    chk("t1_done_once", o_fetch_done, 0);
    chk("t1_idle", o_busy, 0);
    chk("t1_all_weights", exp_q.size(), 0);

    // T2: three back-to-back rows without bubbles
    add_spike(10'd1); add_spike(10'd2); add_spike(10'd3);
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0;
    @(negedge clk);
    chk("t2_c1_pop", o_spike_addr_fifo_rden, 1);
    for (int k = 0; k < 3*NP; k++) begin
      @(negedge clk);
      chk("t2_stream", o_syn_mem_rden, 1);
      if (k == NP-1 || k == 2*NP-1) chk("t2_pop_at_last", o_spike_addr_fifo_rden, 1);
      if (k == 3*NP-1) chk("t2_no_pop_end", o_spike_addr_fifo_rden, 0);
    end
    @(negedge clk);
    chk("t2_stream_end", o_syn_mem_rden, 0);
    wait_done(60, found);
    chk("t2_done_seen", found, 1);
    chk("t2_count", o_spike_count, 3);
    chk("t2_all_weights", exp_q.size(), 0);

    // T3: backpressure, credit stall and full-rate resume
    add_spike(10'd7); add_spike(10'd8);
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0; i_weight_ready = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c >= 6) chk("t3_stall_read", o_syn_mem_rden, 0);
      if (c >= 8) begin
        chk("t3_hold_valid", o_weight_valid, 1);
        chk("t3_hold_data", o_weight_data, wgen(14'h070));
        chk("t3_hold_post", o_weight_post_idx, 0);
      end
    end
    @(posedge clk); #1 i_weight_ready = 1'b1;
    for (int c = 0; c < 2*NP; c++) begin
      @(negedge clk);
      chk("t3_resume_rate", o_weight_valid, 1);
    end
    @(negedge clk);
    chk("t3_empty_after", o_weight_valid, 0);
    wait_done(40, found);
    chk("t3_done_seen", found, 1);
    chk("t3_count", o_spike_count, 2);
    chk("t3_all_weights", exp_q.size(), 0);

    // T4: empty FIFO batch
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0;
    @(negedge clk);
    chk("t4_c1_busy", o_busy, 1);
    chk("t4_c1_noread", o_syn_mem_rden, 0);
    @(negedge clk);
    chk("t4_c2_nodone", o_fetch_done, 0);
    @(negedge clk);
    chk("t4_c3_done", o_fetch_done, 1);
    chk("t4_c3_noread", o_syn_mem_rden, 0);
    chk("t4_count", o_spike_count, 0);
    @(negedge clk);
    chk("t4_idle", o_busy, 0);

    // T5: one-cycle reset with reads in flight
    add_spike(10'd9);
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    expa_q.delete();
    @(negedge clk);
    chk("t5_valid", o_weight_valid, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_done", o_fetch_done, 0);
    chk("t5_count", o_spike_count, 0);
    chk("t5_mem_rden", o_syn_mem_rden, 0);
    chk("t5_mem_addr", o_syn_mem_addr, 0);
    chk("t5_data", o_weight_data, 0);
    chk("t5_last", o_weight_last, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_stale", o_weight_valid, 0);
    end
    add_spike(10'd10);
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0;
    wait_done(40, found);
    chk("t5_done_seen", found, 1);
    chk("t5_count_after", o_spike_count, 1);
    chk("t5_all_weights", exp_q.size(), 0);

    // T6: start in DRAIN/DONE ignored; spike pushed in DRAIN waits for next batch
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 i_start_fetch = 1'b1; add_spike(10'd11);
    @(negedge clk);
    chk("t6_drain_nopop", o_spike_addr_fifo_rden, 0);
    @(negedge clk);
    chk("t6_done", o_fetch_done, 1);
    chk("t6_done_nopop", o_spike_addr_fifo_rden, 0);
    chk("t6_count", o_spike_count, 0);
    @(posedge clk); #1 i_start_fetch = 1'b0;
    @(negedge clk);
    chk("t6_start_ignored", o_busy, 0);
    @(posedge clk); #1 i_start_fetch = 1'b1;
    @(posedge clk); #1 i_start_fetch = 1'b0;
    @(negedge clk);
    chk("t6_next_pop", o_spike_addr_fifo_rden, 1);
    wait_done(40, found);
    chk("t6_done_seen", found, 1);
    chk("t6_count_next", o_spike_count, 1);
    chk("t6_all_weights", exp_q.size(), 0);
    chk("t6_all_reads", expa_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
